rf_write_scheduler: RTL and testbench
=====================================

RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter DEPTH, default 4, deferred-write FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter OP2_REG, default 4'b1111, fixed target of second-result writes.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 wb_valid  in  1  pipeline writeback request this cycle.
REQ-007 wb_reg  in  4  writeback target register.
REQ-008 wb_data  in  DATA_W  writeback data.
REQ-009 wb_op2  in  1  second result present (valid only with wb_valid).
REQ-010 wb_data2  in  DATA_W  second result, written to OP2_REG.
REQ-011 mc_valid / mc_reg / mc_data  in  1 / 4 / DATA_W  multi-cycle unit write request.
REQ-012 mc_ready  out  1  request accepted when mc_valid && mc_ready.
REQ-013 init_done  out  1  register-file clear sequence complete.
REQ-014 pend_mask  out  16  one bit per register with a write queued or in flight.
REQ-015 RegWrite, WriteOP2  out  1 each  port-1 / port-2 write enables to RegisterFile.
REQ-016 WriteReg1, WriteReg2  out  4 each  port addresses.
REQ-017 WriteData1, WriteData2  out  DATA_W each  port data.

Function
REQ-018 FSM states INIT, RUN; reset enters INIT.
REQ-019 INIT: 3-bit counter k=0..7; each cycle port1 writes reg 2k, port2 writes reg 2k+1, data 0, both enables 1.
REQ-020 After k=7 issued, next cycle state=RUN, init_done=1 (held until reset); INIT lasts exactly 8 cycles.
REQ-021 INIT: wb_* ignored, mc_ready=0, no FIFO push.
REQ-022 RUN: mc_ready = (FIFO count != DEPTH); push on mc_valid && mc_ready.
REQ-023 RUN port1 source: wb (wb_reg, wb_data) if wb_valid, else FIFO head if non-empty, else idle.
REQ-024 RUN port2 source: (OP2_REG, wb_data2) if wb_valid && wb_op2; else next unused FIFO entry in age order; else idle.
REQ-025 FIFO entries drained strictly in order; 0, 1 or 2 pops per cycle.
REQ-026 Port2 SHALL NOT take a FIFO entry whose reg equals the port1 reg that cycle; entry waits (no reorder).
REQ-027 Invariant: WriteOP2=1 implies RegWrite=1; port2 never used alone.
REQ-028 Port outputs registered: request at cycle N drives ports during N+1; FIFO push at N earliest on ports N+2.
REQ-029 Idle port: enable 0, address and data driven 0.
REQ-030 Simultaneous push and pops: count_next = count + push - pops; full with same-cycle pop still rejects (mc_ready from registered count).
REQ-031 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-032 pend_mask = OR of decoded regs of valid FIFO entries and of enabled registered port outputs.
REQ-033 wb_valid to a reg set in pend_mask is upstream protocol violation; behaviour need only obey REQ-026/027.

Reset
REQ-034 On rst: state=INIT, k=0, FIFO empty, all outputs 0 (enables, addresses, data, mc_ready, init_done, pend_mask).
REQ-035 rst mid-operation discards queued writes and restarts full INIT sequence on release.

Structure
REQ-036 Package rf_sched_pkg SHALL hold state enum (INIT, RUN), REG_W=4, NUM_REGS=16, default DATA_W, OP2_REG.
REQ-037 Sub-module rf_sched_fifo: DEPTH-entry FIFO exposing head and head+1, pop count 0..2, count output.

Verification
REQ-038 Release rst -> 8 cycles of paired writes (0,1)..(14,15) data 0, then init_done=1, mc_ready=1.
REQ-039 RUN, wb_valid reg 3 data 0x00AA, wb_op2 data2 0x1234 -> next cycle RegWrite=1 WriteReg1=3, WriteOP2=1 WriteReg2=15 WriteData2=0x1234.
REQ-040 5 mc pushes with wb_valid held high with op2 -> 4 accepted, mc_ready=0, pend_mask set for those regs; release wb -> two per cycle drained, oldest first.
REQ-041 FIFO holds reg 7 then reg 7, no wb -> one write per cycle, port2 idle both cycles.
REQ-042 Push and pop same cycle at count=DEPTH-1 -> count unchanged, no loss, order preserved.
REQ-043 rst asserted with 3 queued entries -> outputs 0 immediately, INIT repeats, queued writes never appear.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_sched_pkg;

    localparam int unsigned REG_W      = 4;
    localparam int unsigned NUM_REGS   = 16;
    localparam int unsigned DATA_W_DEF = 16;
    localparam logic [REG_W-1:0] OP2_REG_DEF = 4'b1111;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot decode of a register number.
    function automatic logic [NUM_REGS-1:0] regBit(input logic [REG_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/rf_sched_fifo.sv
// Deferred-write FIFO: exposes the two oldest entries and retires 0..2 per cycle.
module rf_sched_fifo
    import rf_sched_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [REG_W-1:0]    pushReg,
    input  logic [DATA_W-1:0]   pushData,
    input  logic [1:0]          popCnt,
    output logic [REG_W-1:0]    headReg,
    output logic [DATA_W-1:0]   headData,
    output logic [REG_W-1:0]    nextReg,
    output logic [DATA_W-1:0]   nextData,
    output logic [CNT_W-1:0]    count,
    output logic [NUM_REGS-1:0] validMask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [REG_W-1:0]  regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr1;

    assign rdPtr1   = rdPtr + PTR_W'(1);
    assign headReg  = regMem[rdPtr];
    assign headData = dataMem[rdPtr];
    assign nextReg  = regMem[rdPtr1];
    assign nextData = dataMem[rdPtr1];

    // Storage needs no reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            regMem[wrPtr]  <= pushReg;
            dataMem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            rdPtr <= rdPtr + PTR_W'(popCnt);
            count <= count + CNT_W'(push) - CNT_W'(popCnt);
        end
    end

    // Registers targeted by entries still waiting in the queue.
    always_comb begin
        validMask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                validMask = validMask | regBit(regMem[rdPtr + PTR_W'(i)]);
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates pipeline writeback and multi-cycle unit writes onto the two
// register-file write ports, after an initial clear of all registers.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned      DATA_W  = DATA_W_DEF,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [REG_W-1:0] OP2_REG = OP2_REG_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                wb_op2,
    input  logic [DATA_W-1:0]   wb_data2,
    input  logic                mc_valid,
    input  logic [REG_W-1:0]    mc_reg,
    input  logic [DATA_W-1:0]   mc_data,
    output logic                mc_ready,
    output logic                init_done,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                RegWrite,
    output logic                WriteOP2,
    output logic [REG_W-1:0]    WriteReg1,
    output logic [REG_W-1:0]    WriteReg2,
    output logic [DATA_W-1:0]   WriteData1,
    output logic [DATA_W-1:0]   WriteData2
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t             state, nextState;
    logic [2:0]         k, kNext;
    logic               p1En, p2En;
    logic [REG_W-1:0]   p1Reg, p2Reg;
    logic [DATA_W-1:0]  p1Data, p2Data;
    logic               push;
    logic [1:0]         popCnt;
    logic [REG_W-1:0]   headReg, nextReg, candReg;
    logic [DATA_W-1:0]  headData, nextData, candData;
    logic [CNT_W-1:0]   count;
    logic [NUM_REGS-1:0] fifoMask;

    // Ready and done derive from registered state only.
    assign mc_ready  = (state == RUN) && (count != CNT_W'(DEPTH));
    assign init_done = (state == RUN);
    assign push      = mc_valid && mc_ready;
    assign pend_mask = fifoMask
                     | (RegWrite ? regBit(WriteReg1) : '0)
                     | (WriteOP2 ? regBit(WriteReg2) : '0);

    rf_sched_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pushReg   (mc_reg),
        .pushData  (mc_data),
        .popCnt    (popCnt),
        .headReg   (headReg),
        .headData  (headData),
        .nextReg   (nextReg),
        .nextData  (nextData),
        .count     (count),
        .validMask (fifoMask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            k          <= '0;
            RegWrite   <= 1'b0;
            WriteOP2   <= 1'b0;
            WriteReg1  <= '0;
            WriteReg2  <= '0;
            WriteData1 <= '0;
            WriteData2 <= '0;
        end else begin
            state      <= nextState;
            k          <= kNext;
            RegWrite   <= p1En;
            WriteOP2   <= p2En;
            WriteReg1  <= p1Reg;
            WriteReg2  <= p2Reg;
            WriteData1 <= p1Data;
            WriteData2 <= p2Data;
        end
    end

    always_comb begin
        nextState = state;
        kNext     = k;
        p1En      = 1'b0;
        p2En      = 1'b0;
        p1Reg     = '0;
        p2Reg     = '0;
        p1Data    = '0;
        p2Data    = '0;
        popCnt    = 2'd0;
        candReg   = '0;
        candData  = '0;
        case (state)
            INIT: begin
                p1En  = 1'b1;
                p2En  = 1'b1;
                p1Reg = {k, 1'b0};
                p2Reg = {k, 1'b1};
                kNext = k + 3'd1;
                if (k == 3'd7) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (wb_valid) begin
                    p1En   = 1'b1;
                    p1Reg  = wb_reg;
                    p1Data = wb_data;
                end else if (count != '0) begin
                    p1En   = 1'b1;
                    p1Reg  = headReg;
                    p1Data = headData;
                    popCnt = 2'd1;
                end
                // Port 2 only takes the next-oldest entry, never skipping a blocked one.
                candReg  = (popCnt == 2'd0) ? headReg  : nextReg;
                candData = (popCnt == 2'd0) ? headData : nextData;
                if (wb_valid && wb_op2) begin
                    p2En   = 1'b1;
                    p2Reg  = OP2_REG;
                    p2Data = wb_data2;
                end else if (p1En && (count > CNT_W'(popCnt)) && (candReg != p1Reg)) begin
                    p2En   = 1'b1;
                    p2Reg  = candReg;
                    p2Data = candData;
                    popCnt = popCnt + 2'd1;
                end
            end
            default: nextState = INIT;
        endcase
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Scoreboard bench for rf_write_scheduler: a behavioural model queues the
// expected port writes per cycle and they are compared after each edge.
module tb_rf_write_scheduler;
    import rf_sched_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid = 1'b0, wb_op2 = 1'b0, mc_valid = 1'b0;
    logic [3:0]    wb_reg = '0, mc_reg = '0;
    logic [DW-1:0] wb_data = '0, wb_data2 = '0, mc_data = '0;
    logic          mc_ready, init_done, RegWrite, WriteOP2;
    logic [15:0]   pend_mask;
    logic [3:0]    WriteReg1, WriteReg2;
    logic [DW-1:0] WriteData1, WriteData2;

    always #5 clk = ~clk;

    rf_write_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .OP2_REG(4'hF)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_op2(wb_op2), .wb_data2(wb_data2),
        .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
        .mc_ready(mc_ready), .init_done(init_done), .pend_mask(pend_mask),
        .RegWrite(RegWrite), .WriteOP2(WriteOP2),
        .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteData1(WriteData1), .WriteData2(WriteData2)
    );

    typedef struct packed {
        logic        rw;
        logic        op2;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [15:0] d1;
        logic [15:0] d2;
    } exp_t;

    exp_t        expQ[$];
    logic [19:0] mq[$];
    bit          run;
    int          k;
    int          testCnt = 0;
    int          failCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        testCnt++;
        if (got !== want) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic setIn(input logic wv, input logic [3:0] wr, input logic [15:0] wd,
                         input logic o2, input logic [15:0] wd2,
                         input logic mv, input logic [3:0] mr, input logic [15:0] md);
        wb_valid = wv; wb_reg = wr; wb_data = wd; wb_op2 = o2; wb_data2 = wd2;
        mc_valid = mv; mc_reg = mr; mc_data = md;
    endtask

    task automatic resetModel();
        mq.delete();
        expQ.delete();
        run = 1'b0;
        k   = 0;
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, "_flags"}, 32'({RegWrite, WriteOP2, mc_ready, init_done}), 32'(0));
        checkVal({tag, "_regs"}, 32'({WriteReg1, WriteReg2}), 32'(0));
        checkVal({tag, "_data"}, {WriteData1, WriteData2}, 32'(0));
        checkVal({tag, "_pend"}, 32'(pend_mask), 32'(0));
    endtask

    // Predict this cycle's port writes from the model, then compare after the edge.
    task automatic cycle();
        exp_t        e;
        int          pops;
        bit          accept;
        logic [19:0] h;
        logic [15:0] p;
        e    = '0;
        pops = 0;
        checkVal("init_done", 32'(init_done), 32'(run));
        checkVal("mc_ready", 32'(mc_ready), 32'(run && (mq.size() != DEPTH)));
        if (!run) begin
            e.rw = 1'b1; e.op2 = 1'b1;
            e.r1 = 4'(2 * k); e.r2 = 4'(2 * k + 1);
            k++;
            if (k == 8) run = 1'b1;
        end else begin
            accept = mc_valid && (mq.size() != DEPTH);
            if (wb_valid) begin
                e.rw = 1'b1; e.r1 = wb_reg; e.d1 = wb_data;
            end else if (mq.size() > 0) begin
                h = mq[0];
                e.rw = 1'b1; e.r1 = h[19:16]; e.d1 = h[15:0];
                pops = 1;
            end
            if (wb_valid && wb_op2) begin
                e.op2 = 1'b1; e.r2 = 4'hF; e.d2 = wb_data2;
            end else if (e.rw && mq.size() > pops) begin
                h = mq[pops];
                if (h[19:16] != e.r1) begin
                    e.op2 = 1'b1; e.r2 = h[19:16]; e.d2 = h[15:0];
                    pops++;
                end
            end
            repeat (pops) void'(mq.pop_front());
            if (accept) mq.push_back({mc_reg, mc_data});
        end
        expQ.push_back(e);
        @(posedge clk); #1;
        e = expQ.pop_front();
        p = '0;
        foreach (mq[i]) begin
            h = mq[i];
            p = p | (16'(1) << h[19:16]);
        end
        if (e.rw)  p = p | (16'(1) << e.r1);
        if (e.op2) p = p | (16'(1) << e.r2);
        checkVal("RegWrite", 32'(RegWrite), 32'(e.rw));
        checkVal("WriteOP2", 32'(WriteOP2), 32'(e.op2));
        checkVal("WriteReg1", 32'(WriteReg1), 32'(e.r1));
        checkVal("WriteReg2", 32'(WriteReg2), 32'(e.r2));
        checkVal("WriteData1", 32'(WriteData1), 32'(e.d1));
        checkVal("WriteData2", 32'(WriteData2), 32'(e.d2));
        checkVal("pend_mask", 32'(pend_mask), 32'(p));
        checkVal("op2_implies_rw", 32'(WriteOP2 && !RegWrite), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetModel();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkZero("reset");
        // wb/mc activity during the clear sequence must be ignored
        setIn(1'b1, 4'd3, 16'hDEAD, 1'b1, 16'hBEEF, 1'b1, 4'd4, 16'h5555);
        rst = 1'b0;
        repeat (8) cycle();
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkVal("init_done_after8", 32'(init_done), 32'(1));
        checkVal("mc_ready_after8", 32'(mc_ready), 32'(1));

        // Writeback with second result
        setIn(1'b1, 4'd3, 16'h00AA, 1'b1, 16'h1234, 1'b0, 4'd0, 16'h0);
        cycle();
        checkVal("wb_op2_ports", 32'({RegWrite, WriteReg1, WriteOP2, WriteReg2, WriteData2}),
                 32'({1'b1, 4'd3, 1'b1, 4'd15, 16'h1234}));

        // Fill the FIFO while writeback owns both ports; fifth push rejected
        for (int i = 0; i < 5; i++) begin
            setIn(1'b1, 4'(i), 16'(16'h0A00 + i), 1'b1, 16'(16'h0B00 + i),
                  1'b1, 4'(8 + i), 16'(16'h0100 + i));
            cycle();
        end
        checkVal("full_ready", 32'(mc_ready), 32'(0));
        checkVal("full_pend", 32'(pend_mask & 16'h0F00), 32'(16'h0F00));
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        cycle();
        checkVal("drain_oldest", 32'({WriteReg1, WriteReg2}), 32'({4'd8, 4'd9}));
        repeat (2) cycle();

        // Same register twice: one write per cycle, port 2 idle
        setIn(1'b1, 4'd1, 16'h1111, 1'b1, 16'h2222, 1'b1, 4'd7, 16'h0777);
        cycle();
        setIn(1'b1, 4'd2, 16'h3333, 1'b1, 16'h4444, 1'b1, 4'd7, 16'h0778);
        cycle();
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        cycle();
        checkVal("same_reg_a", 32'({RegWrite, WriteReg1, WriteOP2}), 32'({1'b1, 4'd7, 1'b0}));
        cycle();
        checkVal("same_reg_b", 32'({RegWrite, WriteReg1, WriteOP2}), 32'({1'b1, 4'd7, 1'b0}));
        cycle();

        // Push and single pop together at count DEPTH-1
        setIn(1'b1, 4'd0, 16'h0001, 1'b1, 16'h0002, 1'b1, 4'd5, 16'h0051);
        cycle();
        setIn(1'b1, 4'd0, 16'h0003, 1'b1, 16'h0004, 1'b1, 4'd5, 16'h0052);
        cycle();
        setIn(1'b1, 4'd0, 16'h0005, 1'b1, 16'h0006, 1'b1, 4'd6, 16'h0061);
        cycle();
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b1, 4'd9, 16'h0091);
        cycle();
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        checkVal("pushpop_ready", 32'(mc_ready), 32'(1));
        repeat (4) cycle();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            setIn(1'($urandom_range(0, 3) == 0), 4'($urandom), 16'($urandom),
                  1'($urandom), 16'($urandom),
                  1'($urandom_range(0, 9) < 6), 4'($urandom), 16'($urandom));
            cycle();
        end
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        repeat (6) cycle();

        // Reset with three queued entries: they must never be written
        for (int i = 0; i < 3; i++) begin
            setIn(1'b1, 4'd2, 16'h00C0, 1'b1, 16'h00C1, 1'b1, 4'(10 + i), 16'(16'h0C00 + i));
            cycle();
        end
        setIn(1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0);
        rst = 1'b1;
        #1;
        checkZero("midrst");
        resetModel();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) cycle();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
